camera_stream_framer: RTL and testbench

Packs the camera pixel stream into a self-delimiting byte stream for the UART link, and fills the stream-alignment gap between the camera reader and the pixel CDC FIFO. Runs in the pixel-clock domain. Takes tagged pixels from the camera reader and buffers them. Emits frame headers, row headers and clamped pixel bytes to the async FIFO write port under ready/valid flow control. Byte 0xFF is reserved as the sync marker and never appears outside headers.

---
 rtl/camera_framer_pkg.sv | 29 ++
 rtl/framer_fifo.sv | 50 +++++
 rtl/camera_stream_framer.sv | 153 +++++++++++++++
 tb/tb_camera_stream_framer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_framer_pkg.sv
// Shared types and constants for the camera stream framer.
// Buffer entry layout, output state encoding and byte constants.
package camera_framer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam logic [7:0] TAG_FRAME = 8'h00;
    localparam logic [7:0] TAG_ROW   = 8'h01;
    localparam logic [7:0] FRAME_MAX = 8'd254;
    localparam logic [7:0] PIX_MAX   = 8'hFE;

    typedef struct packed {
        logic        sof;
        logic        sor;
        logic [7:0]  pix;
        logic [15:0] row;
    } framer_entry_t;

    typedef enum logic [1:0] {
        PIX  = 2'd0,
        FHDR = 2'd1,
        RHDR = 2'd2
    } framer_state_t;

    // Keeps the sync marker out of the pixel payload.
    function automatic logic [7:0] clamp_pix(input logic [7:0] p);
        return (p == SYNC_BYTE) ? PIX_MAX : p;
    endfunction

endpackage

// File: rtl/framer_fifo.sv
// First-word-fall-through buffer of framer entries.
// A push to a full buffer is taken when a pop frees a slot in the same cycle.
module framer_fifo
    import camera_framer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  framer_entry_t data_i,
    input  logic          pop_i,
    output framer_entry_t head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    framer_entry_t mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    assign rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/camera_stream_framer.sv
// Packs tagged camera pixels into a sync-delimited byte stream.
// Frame and row headers are inserted ahead of the pixel that starts them.
module camera_stream_framer
    import camera_framer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pix_valid_i,
    input  logic [7:0]  pix_i,
    input  logic [15:0] row_i,
    input  logic [15:0] col_i,
    output logic        out_valid_o,
    output logic [7:0]  out_data_o,
    input  logic        out_ready_i,
    output logic        overflow_o,
    output logic [15:0] drop_count_o,
    output logic [7:0]  frame_count_o
);

    framer_entry_t entry_in, head;
    logic          full, empty, pop, fire, drop;
    framer_state_t state_q, state_eff;
    logic [1:0]    hidx_q;
    logic          hdr_done_q;
    logic [7:0]    frame_q;
    logic          ovf_q, ovf_d;
    logic [15:0]   drops_q, drops_d;
    logic          unused_row_hi;

    assign entry_in.sof = (row_i == 16'd0) && (col_i == 16'd0);
    assign entry_in.sor = (col_i == 16'd0);
    assign entry_in.pix = pix_i;
    assign entry_in.row = row_i;

    framer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (pix_valid_i),
        .data_i (entry_in),
        .pop_i  (pop),
        .head_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    // Header entry is decided in the same cycle the head appears.
    always_comb begin
        state_eff = state_q;
        if (state_q == PIX && !empty && !hdr_done_q) begin
            if (head.sof) begin
                state_eff = FHDR;
            end else if (head.sor) begin
                state_eff = RHDR;
            end
        end
    end

    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = 8'h00;
        unique case (state_eff)
            PIX: begin
                if (!empty) begin
                    out_valid_o = 1'b1;
                    out_data_o  = clamp_pix(head.pix);
                end
            end
            FHDR: begin
                out_valid_o = 1'b1;
                unique case (hidx_q)
                    2'd0:    out_data_o = SYNC_BYTE;
                    2'd1:    out_data_o = TAG_FRAME;
                    default: out_data_o = frame_q;
                endcase
            end
            RHDR: begin
                out_valid_o = 1'b1;
                unique case (hidx_q)
                    2'd0:    out_data_o = SYNC_BYTE;
                    2'd1:    out_data_o = TAG_ROW;
                    2'd2:    out_data_o = {1'b0, head.row[13:7]};
                    default: out_data_o = {1'b0, head.row[6:0]};
                endcase
            end
            default: begin
                out_valid_o = 1'b0;
                out_data_o  = 8'h00;
            end
        endcase
    end

    assign unused_row_hi = ^head.row[15:14];

    assign fire = out_valid_o && out_ready_i;
    assign pop  = fire && (state_eff == PIX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= PIX;
            hidx_q     <= 2'd0;
            hdr_done_q <= 1'b0;
            frame_q    <= 8'd0;
        end else begin
            state_q <= state_eff;
            if (fire) begin
                unique case (state_eff)
                    PIX: hdr_done_q <= 1'b0;
                    FHDR: begin
                        if (hidx_q == 2'd2) begin
                            state_q <= RHDR;
                            hidx_q  <= 2'd0;
                            frame_q <= (frame_q == FRAME_MAX) ? 8'd0
                                                              : frame_q + 8'd1;
                        end else begin
                            hidx_q <= hidx_q + 2'd1;
                        end
                    end
                    RHDR: begin
                        if (hidx_q == 2'd3) begin
                            state_q    <= PIX;
                            hidx_q     <= 2'd0;
                            hdr_done_q <= 1'b1;
                        end else begin
                            hidx_q <= hidx_q + 2'd1;
                        end
                    end
                    default: state_q <= PIX;
                endcase
            end
        end
    end

    assign drop    = pix_valid_i && full && !pop;
    assign ovf_d   = ovf_q || drop;
    assign drops_d = (drop && drops_q != 16'hFFFF) ? drops_q + 16'd1 : drops_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q   <= 1'b0;
            drops_q <= 16'd0;
        end else begin
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
        end
    end

    assign overflow_o    = ovf_q;
    assign drop_count_o  = drops_q;
    assign frame_count_o = frame_q;

endmodule

// File: tb/tb_camera_stream_framer.sv
// Self-checking bench for camera_stream_framer.
// Table vectors, corner sequences and randomized traffic vs a stream model.
module tb_camera_stream_framer;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic [7:0]  pix_i = 8'h00;
    logic [15:0] row_i = 16'h0;
    logic [15:0] col_i = 16'h0;
    logic        out_ready_i = 1'b0;
    logic        out_valid_o;
    logic [7:0]  out_data_o;
    logic        overflow_o;
    logic [15:0] drop_count_o;
    logic [7:0]  frame_count_o;

    always #5 clk = ~clk;

    camera_stream_framer #(.DEPTH(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .pix_valid_i  (pix_valid_i),
        .pix_i        (pix_i),
        .row_i        (row_i),
        .col_i        (col_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .overflow_o   (overflow_o),
        .drop_count_o (drop_count_o),
        .frame_count_o(frame_count_o)
    );

    typedef struct {
        logic [7:0] b;
        bit         is_pix;
    } exp_t;

    typedef struct {
        logic [15:0] r;
        logic [15:0] c;
        logic [7:0]  p;
        int          n;
        logic [63:0] e;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    exp_t       expq[$];
    logic [7:0] got[$];
    int         n_pushed = 0;
    int         n_pix_seen = 0;
    int         fc_m = 0;
    bit         rnd_ready = 0;
    bit         hold_v = 0;
    logic [7:0] hold_d = 8'h00;
    vec_t       vt[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Stream model: a frame start gets a frame header, every row start a
    // row header, then the clamped pixel byte.
    function automatic void model_pix(input logic [15:0] r,
                                      input logic [15:0] c,
                                      input logic [7:0] p);
        int rr;
        exp_t x;
        rr = int'(r) % 16384;
        if (r == 16'd0 && c == 16'd0) begin
            x.is_pix = 0;
            x.b = 8'hFF; expq.push_back(x);
            x.b = 8'h00; expq.push_back(x);
            x.b = 8'(fc_m); expq.push_back(x);
            fc_m = (fc_m + 1) % 255;
        end
        if (c == 16'd0) begin
            x.is_pix = 0;
            x.b = 8'hFF; expq.push_back(x);
            x.b = 8'h01; expq.push_back(x);
            x.b = 8'(rr / 128); expq.push_back(x);
            x.b = 8'(rr % 128); expq.push_back(x);
        end
        x.is_pix = 1;
        x.b = (p == 8'hFF) ? 8'hFE : p;
        expq.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (!rst_ni) begin
            hold_v = 0;
        end else begin
            if (hold_v)
                chk("hold_stable", {23'd0, out_valid_o, out_data_o},
                    {23'd0, 1'b1, hold_d});
            if (out_valid_o && out_ready_i) begin
                if (got.size() < expq.size() && expq[got.size()].is_pix)
                    n_pix_seen++;
                got.push_back(out_data_o);
            end
            hold_v = out_valid_o && !out_ready_i;
            hold_d = out_data_o;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready_i = 1'($urandom_range(0, 1));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pix_valid_i = 1'b0;
        end
    endtask

    task automatic drive(input logic [15:0] r, input logic [15:0] c,
                         input logic [7:0] p);
        @(posedge clk);
        #1;
        pix_valid_i = 1'b1;
        row_i = r;
        col_i = c;
        pix_i = p;
        n_pushed++;
    endtask

    task automatic drive_capped(input logic [15:0] r, input logic [15:0] c,
                                input logic [7:0] p);
        int w = 0;
        while (n_pushed - n_pix_seen >= 12 && w < 1000) begin
            idle(1);
            w++;
        end
        if (w >= 1000) chk("cap_wait", 32'(w), 32'd0);
        model_pix(r, c, p);
        drive(r, c, p);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        pix_valid_i = 1'b0;
        rnd_ready = 0;
        out_ready_i = 1'b0;
        expq.delete();
        got.delete();
        n_pushed = 0;
        n_pix_seen = 0;
        fc_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        out_ready_i = v;
        pix_valid_i = 1'b0;
    endtask

    task automatic wait_stream(input string nm, input int budget);
        int cyc = 0;
        while (got.size() < expq.size() && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_len"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), {24'd0, got[i]},
                {24'd0, expq[i].b});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'd0,     16'd0, 8'h10, 8, 64'hFF0000FF01000010};
        vt[1] = '{16'd0,     16'd1, 8'h11, 1, 64'h1100000000000000};
        vt[2] = '{16'd0,     16'd2, 8'h12, 1, 64'h1200000000000000};
        vt[3] = '{16'd1,     16'd0, 8'h13, 5, 64'hFF01000113000000};
        vt[4] = '{16'd1,     16'd1, 8'h14, 1, 64'h1400000000000000};
        vt[5] = '{16'd1,     16'd2, 8'h15, 1, 64'h1500000000000000};
        vt[6] = '{16'd200,   16'd0, 8'hFF, 5, 64'hFF010148FE000000};
        vt[7] = '{16'd200,   16'd1, 8'hFE, 1, 64'hFE00000000000000};
        vt[8] = '{16'd0,     16'd0, 8'h00, 8, 64'hFF0001FF01000000};
        vt[9] = '{16'd16584, 16'd0, 8'h7F, 5, 64'hFF0101487F000000};

        do_reset();
        idle(1);
        chk("reset_valid", {31'd0, out_valid_o}, 32'd0);
        chk("reset_data", {24'd0, out_data_o}, 32'd0);
        chk("reset_ovf", {31'd0, overflow_o}, 32'd0);
        chk("reset_drops", {16'd0, drop_count_o}, 32'd0);
        chk("reset_frame", {24'd0, frame_count_o}, 32'd0);

        set_ready(1'b1);
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < vt[i].n; k++) begin
                exp_t x;
                x.b = vt[i].e[63-8*k -: 8];
                x.is_pix = (k == vt[i].n - 1);
                expq.push_back(x);
            end
            drive(vt[i].r, vt[i].c, vt[i].p);
        end
        idle(1);
        wait_stream("table", 300);
        chk("table_frames", {24'd0, frame_count_o}, 32'd2);
        chk("table_ovf", {31'd0, overflow_o}, 32'd0);

        do_reset();
        rnd_ready = 1;
        for (int f = 0; f < 3; f++) begin
            int nr = $urandom_range(2, 4);
            int nc = $urandom_range(1, 6);
            for (int r = 0; r < nr; r++) begin
                logic [15:0] rv;
                rv = (r == 0) ? 16'd0 : 16'($urandom);
                for (int c = 0; c < nc; c++) begin
                    logic [7:0] pv;
                    pv = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                    drive_capped(rv, 16'(c), pv);
                    if ($urandom_range(0, 1) == 1) idle(1);
                end
            end
        end
        idle(1);
        wait_stream("rand", 4000);
        chk("rand_ovf", {31'd0, overflow_o}, 32'd0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) model_pix(16'd0, 16'(i), 8'(8'h20 + i));
            drive(16'd0, 16'(i), 8'(8'h20 + i));
        end
        idle(3);
        chk("ovf20_flag", {31'd0, overflow_o}, 32'd1);
        chk("ovf20_drops", {16'd0, drop_count_o}, 32'd4);
        chk("ovf20_silent", 32'(got.size()), 32'd0);
        set_ready(1'b1);
        wait_stream("ovf20", 200);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            model_pix(16'd0, 16'(i), 8'(8'h40 + i));
            drive(16'd0, 16'(i), 8'(8'h40 + i));
        end
        for (int j = 0; j < 12; j++) begin
            if (j >= 7) model_pix(16'd0, 16'(16 + j), 8'(8'h60 + j));
            drive(16'd0, 16'(16 + j), 8'(8'h60 + j));
            out_ready_i = 1'b1;
        end
        idle(1);
        wait_stream("fullpop", 200);
        chk("fullpop_drops", {16'd0, drop_count_o}, 32'd7);

        do_reset();
        set_ready(1'b1);
        for (int k = 0; k < 256; k++)
            drive_capped(16'd0, 16'd0, 8'($urandom));
        idle(1);
        wait_stream("frames", 6000);
        chk("frames_count", {24'd0, frame_count_o}, 32'd1);

        set_ready(1'b0);
        drive(16'd0, 16'd0, 8'h33);
        idle(3);
        chk("fhdr_valid", {31'd0, out_valid_o}, 32'd1);
        chk("fhdr_byte", {24'd0, out_data_o}, 32'hFF);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("async_rst_frame", {24'd0, frame_count_o}, 32'd0);
        do_reset();
        set_ready(1'b1);
        model_pix(16'd0, 16'd0, 8'h44);
        drive(16'd0, 16'd0, 8'h44);
        idle(1);
        wait_stream("after_rst", 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
